// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: S1 registers the operands, S2 registers
// the result with its zero/parity flags. A saturating counter tallies delivered results.
module logic_unit_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [2:0]         out_op,
    output logic               out_zero,
    output logic               out_parity,
    input  logic               clr_count,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;

    logic               s1_valid_reg;
    logic [2:0]         s1_op_reg;
    logic [WIDTH-1:0]   s1_a_reg;
    logic [WIDTH-1:0]   s1_b_reg;
    logic               s2_valid_reg;
    logic [WIDTH-1:0]   s2_result_reg;
    logic [2:0]         s2_op_reg;
    logic               s2_zero_reg;
    logic               s2_parity_reg;
    logic [COUNT_W-1:0] count_reg;

    logic [WIDTH-1:0]   result_next;
    logic               s2_load;
    logic               in_fire;
    logic               out_fire;

    function automatic logic gate_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        r = a;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign result_next[gi] = gate_bit(s1_op_reg, s1_a_reg[gi], s1_b_reg[gi]);
        end
    endgenerate

    // in_ready depends on out_ready through s2_load so a full pipe still streams at 1 beat/cycle.
    assign s2_load  = s1_valid_reg && (!s2_valid_reg || out_ready);
    assign in_ready = !rst && (!s1_valid_reg || s2_load);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= in_op;
            s1_a_reg     <= in_a;
            s1_b_reg     <= in_b;
        end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_op_reg     <= '0;
            s2_zero_reg   <= 1'b0;
            s2_parity_reg <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg  <= 1'b1;
            s2_result_reg <= result_next;
            s2_op_reg     <= s1_op_reg;
            s2_zero_reg   <= (result_next == '0);
            s2_parity_reg <= ^result_next;
        end else if (out_fire) begin
            s2_valid_reg  <= 1'b0;
        end
    end

    // Clear takes priority over a coincident handshake.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            count_reg <= '0;
        end else if (out_fire && (count_reg != {COUNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_result = s2_result_reg;
    assign out_op     = s2_op_reg;
    assign out_zero   = s2_zero_reg;
    assign out_parity = s2_parity_reg;
    assign op_count   = count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: an 8-bit/2-bit-counter instance for directed tests and a
// 13-bit instance for random traffic.
module tb_logic_unit_pipe;

    typedef struct {
        logic [2:0]  op;
        logic [12:0] res;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } beat_t;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       par;
    } obs_t;

    logic clk;
    logic rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, clr8;
    logic [2:0]  in_op8, out_op8;
    logic [7:0]  in_a8, in_b8, out_result8;
    logic        out_zero8, out_parity8;
    logic [1:0]  cnt8;

    logic        in_valid13, in_ready13, out_valid13, out_ready13, clr13;
    logic [2:0]  in_op13, out_op13;
    logic [12:0] in_a13, in_b13, out_result13;
    logic        out_zero13, out_parity13;
    logic [15:0] cnt13;

    int checks = 0;
    int errors = 0;

    exp_t  sb8[$];
    exp_t  sb13[$];
    beat_t pend8[$];
    obs_t  obs8[$];
    int    cyc8 = 0;
    int    n_in8 = 0;
    int    n_out8 = 0;
    int    n_out13 = 0;
    bit    chk_lat = 0;
    bit    stall8 = 0;
    bit    hold13 = 0;
    logic [7:0] held8;
    logic [2:0] heldop8;

    logic_unit_pipe #(.WIDTH(8), .COUNT_W(2)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8), .in_a(in_a8), .in_b(in_b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8), .out_op(out_op8),
        .out_zero(out_zero8), .out_parity(out_parity8), .clr_count(clr8), .op_count(cnt8)
    );

    logic_unit_pipe #(.WIDTH(13), .COUNT_W(16)) dut13 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid13), .in_ready(in_ready13), .in_op(in_op13), .in_a(in_a13), .in_b(in_b13),
        .out_valid(out_valid13), .out_ready(out_ready13), .out_result(out_result13), .out_op(out_op13),
        .out_zero(out_zero13), .out_parity(out_parity13), .clr_count(clr13), .op_count(cnt13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] model(input logic [2:0] op, input logic [12:0] a, input logic [12:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // One cycle on the 8-bit instance; called at a falling edge, returns at the next one.
    task automatic step8(input logic ordy);
        exp_t e;
        obs_t o;
        if (pend8.size() > 0) begin
            in_valid8 = 1'b1;
            in_op8 = pend8[0].op;
            in_a8 = pend8[0].a;
            in_b8 = pend8[0].b;
        end else begin
            in_valid8 = 1'b0;
        end
        out_ready8 = ordy;
        #1;
        if (stall8) begin
            checks++;
            if (out_result8 !== held8 || out_op8 !== heldop8) begin
                errors++;
                $display("FAIL stall_stable got %h/%0d exp %h/%0d", out_result8, out_op8, held8, heldop8);
            end
        end
        if (in_valid8 && in_ready8) begin
            e.op  = in_op8;
            e.res = model(in_op8, {5'b0, in_a8}, {5'b0, in_b8}) & 13'h0FF;
            e.cyc = cyc8;
            sb8.push_back(e);
            void'(pend8.pop_front());
            n_in8++;
        end
        if (out_valid8 && out_ready8) begin
            n_out8++;
            checks++;
            if (sb8.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out8 got %h exp none", out_result8);
            end else begin
                e = sb8.pop_front();
                if (out_result8 !== e.res[7:0] || out_op8 !== e.op ||
                    out_zero8 !== (e.res[7:0] == 8'h00) || out_parity8 !== ^e.res[7:0]) begin
                    errors++;
                    $display("FAIL out8 got res=%h op=%0d z=%b p=%b exp res=%h op=%0d z=%b p=%b",
                             out_result8, out_op8, out_zero8, out_parity8,
                             e.res[7:0], e.op, (e.res[7:0] == 8'h00), ^e.res[7:0]);
                end
                if (chk_lat) begin
                    checks++;
                    if (cyc8 - e.cyc != 2) begin
                        errors++;
                        $display("FAIL latency got %0d exp 2", cyc8 - e.cyc);
                    end
                end
            end
            o.res = out_result8;
            o.zero = out_zero8;
            o.par = out_parity8;
            obs8.push_back(o);
            $display("out8 res=%h op=%0d zero=%b parity=%b cnt=%0d", out_result8, out_op8, out_zero8, out_parity8, cnt8);
        end
        stall8  = out_valid8 && !out_ready8;
        held8   = out_result8;
        heldop8 = out_op8;
        cyc8++;
        @(negedge clk);
    endtask

    task automatic step13(input bit rnd);
        exp_t e;
        if (!hold13) begin
            if (rnd) begin
                in_valid13 = ($urandom_range(0, 3) != 0);
                in_op13 = 3'($urandom_range(0, 7));
                in_a13 = 13'($urandom);
                in_b13 = 13'($urandom);
            end else begin
                in_valid13 = 1'b0;
            end
        end
        out_ready13 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        if (in_valid13 && in_ready13) begin
            e.op = in_op13;
            e.res = model(in_op13, in_a13, in_b13);
            e.cyc = 0;
            sb13.push_back(e);
        end
        hold13 = in_valid13 && !in_ready13;
        if (out_valid13 && out_ready13) begin
            n_out13++;
            checks++;
            if (sb13.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out13 got %h exp none", out_result13);
            end else begin
                e = sb13.pop_front();
                if (out_result13 !== e.res || out_op13 !== e.op ||
                    out_zero13 !== (e.res == 13'h0) || out_parity13 !== ^e.res) begin
                    errors++;
                    $display("FAIL out13 got res=%h op=%0d z=%b p=%b exp res=%h op=%0d",
                             out_result13, out_op13, out_zero13, out_parity13, e.res, e.op);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0 || out_result8 !== 8'h00 || out_op8 !== 3'd0 ||
            out_zero8 !== 1'b0 || out_parity8 !== 1'b0 || cnt8 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b res=%h op=%0d z=%b p=%b cnt=%0d exp all 0",
                     in_ready8, out_valid8, out_result8, out_op8, out_zero8, out_parity8, cnt8);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || in_ready13 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b/%b exp 1/1", in_ready8, in_ready13);
        end
        $display("reset done");
        @(negedge clk);
    endtask

    task automatic test_truth_table();
        logic [7:0] tt_res [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        obs8.delete();
        for (int i = 0; i < 8; i++) pend8.push_back('{3'(i), 8'hF0, 8'hCC});
        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) step8(1'b1);
        chk_lat = 1'b0;
        checks++;
        if (obs8.size() != 8) begin
            errors++;
            $display("FAIL truth_count got %0d exp 8", obs8.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs8[i].res !== tt_res[i] || obs8[i].zero !== 1'b0 || obs8[i].par !== 1'b0) begin
                    errors++;
                    $display("FAIL truth_op%0d got %h z=%b p=%b exp %h z=0 p=0",
                             i, obs8[i].res, obs8[i].zero, obs8[i].par, tt_res[i]);
                end
            end
        end
    endtask

    task automatic test_flags();
        obs8.delete();
        pend8.push_back('{3'd4, 8'hA5, 8'hA5});
        pend8.push_back('{3'd7, 8'h01, 8'h5A});
        for (int i = 0; i < 6; i++) step8(1'b1);
        checks++;
        if (obs8.size() != 2) begin
            errors++;
            $display("FAIL flags_count got %0d exp 2", obs8.size());
        end else begin
            if (obs8[0].res !== 8'h00 || obs8[0].zero !== 1'b1 || obs8[0].par !== 1'b0) begin
                errors++;
                $display("FAIL flags_xor got %h z=%b p=%b exp 00 z=1 p=0", obs8[0].res, obs8[0].zero, obs8[0].par);
            end
            checks++;
            if (obs8[1].res !== 8'h01 || obs8[1].zero !== 1'b0 || obs8[1].par !== 1'b1) begin
                errors++;
                $display("FAIL flags_pass got %h z=%b p=%b exp 01 z=0 p=1", obs8[1].res, obs8[1].zero, obs8[1].par);
            end
        end
    endtask

    task automatic test_backpressure();
        int in0;
        int out0;
        in0 = n_in8;
        pend8.push_back('{3'd0, 8'h3C, 8'h0F});
        pend8.push_back('{3'd1, 8'h12, 8'h40});
        pend8.push_back('{3'd4, 8'hFF, 8'h81});
        pend8.push_back('{3'd6, 8'h55, 8'h00});
        for (int i = 0; i < 5; i++) step8(1'b0);
        checks++;
        if (n_in8 - in0 != 2 || in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got %0d rdy=%b exp 2 rdy=0", n_in8 - in0, in_ready8);
        end
        out0 = n_out8;
        for (int i = 0; i < 8; i++) step8(1'b1);
        checks++;
        if (n_out8 - out0 != 4 || sb8.size() != 0 || pend8.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got %0d left=%0d exp 4 left=0", n_out8 - out0, sb8.size());
        end
    endtask

    task automatic test_counter();
        int out0;
        clr8 = 1'b1;
        step8(1'b1);
        clr8 = 1'b0;
        checks++;
        if (cnt8 !== 2'd0) begin
            errors++;
            $display("FAIL cnt_clear got %0d exp 0", cnt8);
        end
        for (int i = 0; i < 5; i++) pend8.push_back('{3'd7, 8'(i + 1), 8'h00});
        for (int i = 0; i < 10; i++) step8(1'b1);
        checks++;
        if (cnt8 !== 2'd3) begin
            errors++;
            $display("FAIL cnt_saturate got %0d exp 3", cnt8);
        end
        pend8.push_back('{3'd5, 8'h0F, 8'hF0});
        for (int i = 0; i < 6 && !out_valid8; i++) step8(1'b0);
        out0 = n_out8;
        clr8 = 1'b1;
        step8(1'b1);
        clr8 = 1'b0;
        checks++;
        if (n_out8 - out0 != 1 || cnt8 !== 2'd0) begin
            errors++;
            $display("FAIL cnt_clr_wins got hs=%0d cnt=%0d exp hs=1 cnt=0", n_out8 - out0, cnt8);
        end
    endtask

    task automatic test_reset_mid();
        int out0;
        pend8.push_back('{3'd1, 8'h11, 8'h22});
        pend8.push_back('{3'd2, 8'h33, 8'h44});
        for (int i = 0; i < 3; i++) step8(1'b0);
        rst = 1'b1;
        in_valid8 = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got %b exp 0", in_ready8);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || out_result8 !== 8'h00 || out_op8 !== 3'd0 || out_zero8 !== 1'b0 ||
            out_parity8 !== 1'b0 || cnt8 !== 2'd0 || in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b res=%h op=%0d z=%b p=%b cnt=%0d rdy=%b exp all 0",
                     out_valid8, out_result8, out_op8, out_zero8, out_parity8, cnt8, in_ready8);
        end
        rst = 1'b0;
        sb8.delete();
        pend8.delete();
        stall8 = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL ready_post_reset got %b exp 1", in_ready8);
        end
        @(negedge clk);
        out0 = n_out8;
        for (int i = 0; i < 5; i++) step8(1'b1);
        checks++;
        if (n_out8 != out0) begin
            errors++;
            $display("FAIL stale_beat got %0d outputs exp 0", n_out8 - out0);
        end
    endtask

    task automatic test_random();
        n_out13 = 0;
        sb13.delete();
        for (int i = 0; i < 1000; i++) step13(1'b1);
        for (int i = 0; i < 10; i++) step13(1'b0);
        checks++;
        if (sb13.size() != 0 || hold13) begin
            errors++;
            $display("FAIL random_drain got %0d pending exp 0", sb13.size());
        end
        checks++;
        if (cnt13 !== 16'(n_out13)) begin
            errors++;
            $display("FAIL random_count got %0d exp %0d", cnt13, n_out13);
        end
        $display("random done handshakes=%0d", n_out13);
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; in_op8 = 3'd0; in_a8 = 8'h00; in_b8 = 8'h00; out_ready8 = 1'b0; clr8 = 1'b0;
        in_valid13 = 1'b0; in_op13 = 3'd0; in_a13 = 13'h0; in_b13 = 13'h0; out_ready13 = 1'b0; clr13 = 1'b0;
        test_reset();
        test_truth_table();
        test_flags();
        test_backpressure();
        test_counter();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
